store_narrow_buffer: RTL
========================

# store_narrow_buffer

Store-path counterpart to the load sign/zero extender in the MIPS datapath. It accepts 32-bit register data with a store size from the MEM stage and narrows it to byte or halfword lanes. It generates big-endian byte enables and queues the result in a small store buffer. Entries drain to the data memory over a valid/ack handshake, so the pipeline does not stall on memory latency.

## Interface
- DEPTH, 4, store-buffer entries; power of two, ≥2
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- st_valid  input  1  store request from MEM stage
- st_ready  output  1  buffer can accept; high when occupancy < DEPTH
- st_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- st_addr  input  32  byte address
- st_data  input  32  register data; the low byte or low halfword is used for narrow stores
- st_misalign  output  1  one-cycle pulse: last accepted store was misaligned or illegal and was dropped
- mem_req  output  1  head entry valid
- mem_addr  output  32  word address of head entry, bits [1:0] = 00
- mem_wdata  output  32  lane-replicated write data
- mem_be  output  4  byte enables; be[3] = bits 31:24 = byte offset 0 (big-endian)
- mem_ack  input  1  memory has written head entry this cycle
- sb_empty  output  1  buffer empty; used by SYNC and the drain logic

## Operation
- Acceptance: a store is accepted on a rising edge where st_valid && st_ready.
- st_ready depends only on registered occupancy. It does not anticipate a same-cycle mem_ack.
- Alignment check: a halfword needs addr[0]=0 and a word needs addr[1:0]=00. Size 11 is always illegal.
- Failing stores are accepted (consumed), never enqueued, and set st_misalign for the next cycle only.
- Narrowing, with off = addr[1:0]:
  - Byte: wdata = {4{data[7:0]}}; be = 4'b1000 >> off.
  - Halfword: wdata = {2{data[15:0]}}; be = off[1] ? 0011 : 1100.
  - Word: wdata = data; be = 1111.
- FIFO: holds {word address, wdata, be}, with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Memory side: mem_* are driven from the head entry, and mem_req = (count ≠ 0).
  - Addr, wdata and be stay stable while mem_req is high and mem_ack is low.
  - mem_ack with mem_req high pops the head. mem_ack while mem_req is low is ignored.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
  - This works at count = DEPTH only if st_ready was high, which it is not. So a full buffer never enqueues, even with a same-cycle ack.
- Reset: asynchronous, clears pointers, count and st_misalign.
  - Outputs after reset: mem_req=0, sb_empty=1, st_ready=1, st_misalign=0, mem_addr/mem_wdata/mem_be=0.
  - Reset mid-transaction discards all entries, including an un-acked head.

## Timing
- Enqueue latency: a store accepted at edge N into an empty buffer gives mem_req=1 with its entry after edge N.
- Back-to-back drain: if an ack arrives at edge N and count ≥ 2, the next entry is presented after edge N with no bubble.
- After edge N with the last entry acked: sb_empty=1 and mem_req=0.
- st_misalign is high for exactly the cycle following the edge that accepted the bad store.

## Configuration
- STORE_MERGE_EN defined: a valid aligned store whose word address equals the tail entry's word address merges into the tail instead of enqueuing. Merging is only allowed when count ≥ 2, so the head (in flight) is never modified.
  - Merged be = old | new.
  - Lanes in the new be take the new data; the other lanes keep the old data.
  - A merge consumes no slot, and st_ready is unchanged.
- STORE_MERGE_EN undefined: every aligned store occupies its own entry.

## Test plan
- Byte at 0x1000_0003, data 0x1234_56AB -> mem_addr 0x1000_0000, be 0001, wdata 0xABAB_ABAB; mem_req high one cycle after acceptance.
- Halfword at 0x2000_0002, data 0xFFFF_BEEF, then a word at 0x2000_0004, data 0xCAFE_F00D, with no ack -> head stays stable with be 0011, wdata 0xBEEF_BEEF. Ack -> next cycle shows 0x2000_0004, be 1111, 0xCAFE_F00D.
- Halfword at 0x3000_0001 -> st_misalign pulses one cycle, count unchanged, sb_empty stays 1. Repeat with size 11 at an aligned address -> same result.
- Fill DEPTH entries with ack low -> st_ready=0. Then st_valid together with mem_ack -> no enqueue, count = DEPTH-1, st_ready=1 next cycle. Run 3×DEPTH stores to check pointer wrap and ordering.
- With STORE_MERGE_EN and head in flight: bytes at 0x4000_0000 (0x11) and 0x4000_0001 (0x22) behind a different head -> one entry, be 1100, wdata[31:16] = 0x1122. Without the macro -> two entries.
- Assert reset_n low with 3 entries queued and the head un-acked -> mem_req=0 and sb_empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows MEM-stage store data to byte/halfword/word lanes
// with big-endian byte enables and queues it in a small FIFO that drains to data
// memory over a valid/ack handshake.
// Optional feature: define STORE_MERGE_EN to merge aligned stores into the tail
// entry when they hit the same word and the tail is not the in-flight head.
module store_narrow_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_misalign,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        sb_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [31:0]   n_wdata;
    logic [3:0]    n_be;
    logic          n_legal;
    logic          accept;
    logic          pop;
    logic          enq;
    logic          merge;
    logic [AW-1:0] tail_ptr;
    logic [31:0]   m_wdata;

    assign st_ready = (count != FULL_CNT);
    assign accept   = st_valid && st_ready;
    assign mem_req  = (count != '0);
    assign sb_empty = (count == '0);
    assign pop      = mem_ack && mem_req;
    assign tail_ptr = wr_ptr - AW'(1);
    assign enq      = accept && n_legal && !merge;

    // Head entry drives the memory port; zero while the buffer is empty.
    assign mem_addr  = mem_req ? {addr_q[rd_ptr], 2'b00} : '0;
    assign mem_wdata = mem_req ? data_q[rd_ptr] : '0;
    assign mem_be    = mem_req ? be_q[rd_ptr] : '0;

    // Lane replication, byte enables and alignment check for the incoming store.
    always_comb begin
        n_wdata = st_data;
        n_be    = 4'b1111;
        n_legal = 1'b0;
        case (st_size)
            2'b00: begin
                n_wdata = {4{st_data[7:0]}};
                n_be    = 4'b1000 >> st_addr[1:0];
                n_legal = 1'b1;
            end
            2'b01: begin
                n_wdata = {2{st_data[15:0]}};
                n_be    = st_addr[1] ? 4'b0011 : 4'b1100;
                n_legal = !st_addr[0];
            end
            2'b10: begin
                n_legal = (st_addr[1:0] == 2'b00);
            end
            default: begin
                n_legal = 1'b0;
            end
        endcase
    end

`ifdef STORE_MERGE_EN
    // Merge only behind the head (count >= 2) so the in-flight entry never changes.
    always_comb begin
        merge   = accept && n_legal && (count > (AW + 1)'(1))
                  && (addr_q[tail_ptr] == st_addr[31:2]);
        m_wdata = data_q[tail_ptr];
        for (int i = 0; i < 4; i++) begin
            if (n_be[i]) m_wdata[8*i +: 8] = n_wdata[8*i +: 8];
        end
    end
`else
    // Every aligned store takes its own entry.
    always_comb begin
        merge   = 1'b0;
        m_wdata = n_wdata;
    end
`endif

    // Entry storage; contents are don't-care until counted valid, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr] <= st_addr[31:2];
            data_q[wr_ptr] <= n_wdata;
            be_q[wr_ptr]   <= n_be;
        end else if (merge) begin
            data_q[tail_ptr] <= m_wdata;
            be_q[tail_ptr]   <= be_q[tail_ptr] | n_be;
        end
    end

    // Pointers, occupancy and the misalign pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            st_misalign <= 1'b0;
        end else begin
            st_misalign <= accept && !n_legal;
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
